// File: rtl/decode_issue_pkg.sv
// Shared types, opcode/funct3 constants and the instruction decoder for the decode/issue slice.
package decode_issue_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALU_LAT = 2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } pipe_entry_t;

  typedef struct packed {
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            r_i_s;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
  } decode_t;

  // Classify the word; operands not drawn from registers come from imm.
  function automatic decode_t decode_instr(input logic [XLEN-1:0] instr);
    decode_t d;
    d        = '0;
    d.funct3 = instr[14:12];
    case (instr[6:0])
      OPC_OP: begin
        if (instr[31:25] == 7'd0) begin
          d.legal   = 1'b1;
          d.use_rs1 = 1'b1;
          d.use_rs2 = 1'b1;
          d.r_i_s   = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d.legal   = 1'b1;
        d.use_rs1 = 1'b1;
        d.r_i_s   = 1'b1;
        if (instr[14:12] == F3_SLL || instr[14:12] == F3_SRL)
          d.imm = {27'd0, instr[24:20]};
        else
          d.imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LUI: begin
        d.legal  = 1'b1;
        d.funct3 = F3_ADD;
        d.imm    = {instr[31:12], 12'h000};
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// 32x32 register file: two operand read ports, one debug port, one write port with read bypass.
module decode_issue_regfile
  import decode_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs [32];
  logic            wr_live;

  assign wr_live = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle write is forwarded so a dependent read never sees stale data.
  assign rs1_data = (rs1_addr == '0) ? '0 : (wr_live && waddr == rs1_addr) ? wdata : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : (wr_live && waddr == rs2_addr) ? wdata : regs[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : (wr_live && waddr == dbg_addr) ? wdata : regs[dbg_addr];

endmodule

// File: rtl/decode_issue.sv
// Decode R/I/LUI instructions, issue operands to an external ALU and write results back,
// stalling on read-after-write hazards against results still in flight.
module decode_issue #(
  parameter int unsigned ALU_LAT = decode_issue_pkg::ALU_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] a_in,
  output logic [31:0] b_in,
  output logic [2:0]  funct3,
  output logic        r_i_s_instr_types,
  output logic        in_valid,
  input  logic [31:0] alu_out,
  input  logic        alu_out_valid,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  import decode_issue_pkg::*;

  localparam int unsigned DEPTH = ALU_LAT + 1;

  decode_t         dec;
  pipe_entry_t     pipe [DEPTH];
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            hazard;
  logic            accept;
  logic            issue;
  logic            wb_we;

  always_comb dec = decode_instr(instr);

  // The last entry's result is bypassed this cycle, so only earlier entries stall.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (pipe[i].valid && pipe[i].rd != '0 &&
          ((dec.use_rs1 && instr[19:15] == pipe[i].rd) ||
           (dec.use_rs2 && instr[24:20] == pipe[i].rd)))
        hazard = 1'b1;
    end
  end

  assign instr_ready = rst && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && dec.legal;
  assign wb_we       = alu_out_valid && pipe[DEPTH-1].valid && pipe[DEPTH-1].rd != '0;

  decode_issue_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (instr[19:15]),
    .rs2_addr (instr[24:20]),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data),
    .we       (wb_we),
    .waddr    (pipe[DEPTH-1].rd),
    .wdata    (alu_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_valid          <= 1'b0;
      illegal           <= 1'b0;
      a_in              <= '0;
      b_in              <= '0;
      funct3            <= '0;
      r_i_s_instr_types <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
    end else begin
      in_valid <= issue;
      illegal  <= accept && !dec.legal;
      if (issue) begin
        a_in              <= dec.use_rs1 ? rs1_data : '0;
        b_in              <= dec.use_rs2 ? rs2_data : dec.imm;
        funct3            <= dec.funct3;
        r_i_s_instr_types <= dec.r_i_s;
      end
      pipe[0].valid <= issue;
      pipe[0].rd    <= instr[11:7];
      for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: directed instructions, a small external ALU model,
// and a monitor that checks every issue/illegal strobe against queued expectations.
module tb_decode_issue;
  import decode_issue_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] a_in, b_in;
  logic [2:0]  funct3;
  logic        r_i_s_instr_types;
  logic        in_valid;
  logic [31:0] alu_out;
  logic        alu_out_valid;
  logic        illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  decode_issue #(.ALU_LAT(LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr             (instr),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .a_in              (a_in),
    .b_in              (b_in),
    .funct3            (funct3),
    .r_i_s_instr_types (r_i_s_instr_types),
    .in_valid          (in_valid),
    .alu_out           (alu_out),
    .alu_out_valid     (alu_out_valid),
    .illegal           (illegal),
    .dbg_addr          (dbg_addr),
    .dbg_data          (dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: fixed latency of LAT cycles, not reset (like an independent unit).
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    case (f3)
      3'b001:  return a << b[4:0];
      3'b101:  return a >> b[4:0];
      3'b111:  return a & b;
      3'b110:  return a | b;
      3'b100:  return a ^ b;
      default: return a + b;
    endcase
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [31:0]    pr [LAT];

  always @(posedge clk) begin
    pv[0] <= in_valid;
    pr[0] <= alu(a_in, b_in, funct3);
    for (int i = 1; i < int'(LAT); i++) begin
      pv[i] <= pv[i-1];
      pr[i] <= pr[i-1];
    end
  end

  assign alu_out_valid = pv[LAT-1];
  assign alu_out       = pr[LAT-1];

  typedef struct {
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        ris;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t op_e(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3, input logic ris);
    exp_t e;
    e.ill = 1'b0; e.a = a; e.b = b; e.f3 = f3; e.ris = ris;
    return e;
  endfunction

  function automatic exp_t ill_e();
    exp_t e;
    e.ill = 1'b1; e.a = '0; e.b = '0; e.f3 = '0; e.ris = 1'b0;
    return e;
  endfunction

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (in_valid === 1'b1 || illegal === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got in_valid=%b illegal=%b expected none", in_valid, illegal);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("in_valid", 32'(in_valid), 32'(!e.ill));
        if (!e.ill) begin
          chk("a_in", a_in, e.a);
          chk("b_in", b_in, e.b);
          chk("funct3", 32'(funct3), 32'(e.f3));
          chk("r_i_s", 32'(r_i_s_instr_types), 32'(e.ris));
        end
      end
    end
  end

  task automatic send(input string name, input logic [31:0] w, input exp_t e, input int exp_stalls);
    int stalls;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    stalls      = 0;
    #1;
    while (!instr_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!instr_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept_timeout: got ready=0 expected ready=1 within 20 cycles", name);
      instr_valid = 1'b0;
      return;
    end
    q.push_back(e);
    chk({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = addr;
    #1 chk(name, dbg_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_a_in", a_in, 32'd0);
    chk("rst_b_in", b_in, 32'd0);
    chk("rst_funct3", 32'(funct3), 32'd0);
    chk("rst_r_i_s", 32'(r_i_s_instr_types), 32'd0);
    dbg_addr = 5'd1;
    #1 chk("rst_x1", dbg_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    send("addi_x1",  32'h00500093, op_e(32'd0, 32'd5, 3'b000, 1'b1), 0);
    send("add_x2",   32'h00108133, op_e(32'd5, 32'd5, 3'b000, 1'b1), 2);
    send("slli_x3",  32'h00409193, op_e(32'd5, 32'd4, 3'b001, 1'b1), 0);
    send("addi_x0",  32'h00700013, op_e(32'd0, 32'd7, 3'b000, 1'b1), 0);
    send("sub_x4",   32'h40208233, ill_e(), 0);
    send("addi_x9",  32'hFFF08493, op_e(32'd5, 32'hFFFFFFFF, 3'b000, 1'b1), 0);
    send("lui_x6",   32'h12345337, op_e(32'd0, 32'h12345000, 3'b000, 1'b0), 0);
    send("srli_x8",  32'h00C35413, op_e(32'h12345000, 32'd12, 3'b101, 1'b1), 2);
    repeat (4) @(negedge clk);

    dbg_chk("x0", 5'd0, 32'd0);
    dbg_chk("x1", 5'd1, 32'd5);
    dbg_chk("x2", 5'd2, 32'd10);
    dbg_chk("x3", 5'd3, 32'd80);
    dbg_chk("x4", 5'd4, 32'd0);
    dbg_chk("x6", 5'd6, 32'h12345000);
    dbg_chk("x8", 5'd8, 32'h00012345);
    dbg_chk("x9", 5'd9, 32'd4);

    // Reset lands one cycle after an accept: the in-flight result must be dropped.
    send("addi_x5",  32'h00900293, op_e(32'd0, 32'd9, 3'b000, 1'b1), 0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_valid", 32'(in_valid), 32'd0);
    chk("post_rst_a_in", a_in, 32'd0);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    repeat (5) @(negedge clk);
    dbg_chk("x5_dropped", 5'd5, 32'd0);
    dbg_chk("x1_cleared", 5'd1, 32'd0);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter: ALU_LAT, default 2, cycles from in_valid high to matching alu_out_valid high.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: instr  input  32  RV32 instruction word.
REQ-005 Port: instr_valid  input  1  instr present.
REQ-006 Port: instr_ready  output  1  instr accepted this cycle when valid&&ready.
REQ-007 Port: a_in, b_in  output  32 each  ALU operands, registered.
REQ-008 Port: funct3  output  3  ALU op select, registered.
REQ-009 Port: r_i_s_instr_types  output  1  high for R/I-type ops, registered.
REQ-010 Port: in_valid  output  1  ALU operand strobe, registered.
REQ-011 Port: alu_out  input  32  ALU result.
REQ-012 Port: alu_out_valid  input  1  ALU result strobe.
REQ-013 Port: illegal  output  1  one-cycle pulse, unsupported instruction consumed.
REQ-014 Port: dbg_addr  input  5 / dbg_data  output  32  combinational register-file read, bypass applied.

Function
REQ-015 Decode OP (0110011), funct7=0: a=x[rs1], b=x[rs2], r_i_s=1, funct3=instr[14:12].
REQ-016 Decode OP-IMM (0010011): a=x[rs1], r_i_s=1; funct3 001/101: b=zero-ext instr[24:20]; else b=sign-ext instr[31:20].
REQ-017 Decode LUI (0110111): a=0, b={instr[31:12],12'h0}, r_i_s=0, funct3=000.
REQ-018 All other opcodes, and OP with funct7!=0: consumed, illegal=1 next cycle, in_valid=0, no rd tracked.
REQ-019 Issue latency: accept at edge N -> in_valid, operands, funct3, r_i_s valid in cycle after edge N, for exactly one cycle.
REQ-020 Throughput: one independent instruction per cycle; in_valid=0 in cycles with no accept.
REQ-021 Track in-flight rd in ALU_LAT+1 entry shift pipe (valid, rd); entry 0 loads on issue, shifts every cycle.
REQ-022 Last pipe entry aligns with alu_out_valid; write x[rd]=alu_out when alu_out_valid && entry valid && rd!=0.
REQ-023 alu_out_valid with no valid last entry: result dropped.
REQ-024 Register file: 32x32, x0 reads 0, writes to x0 ignored.
REQ-025 Read bypass: reading a register written in the same cycle returns alu_out.
REQ-026 Hazard: instr_ready=0 when decoded rs1 or rs2 (nonzero, used by opcode) matches valid rd in any pipe entry except last; otherwise instr_ready=1.
REQ-027 LUI and x0 sources never hazard.
REQ-028 instr_ready=0 while rst low.

Reset
REQ-029 rst low at edge: in_valid=0, illegal=0, a_in=b_in=0, funct3=0, r_i_s=0, all pipe entries invalid, all registers 0.
REQ-030 Reset mid-operation: in-flight results discarded; first accept possible on first edge after rst returns high.

Structure
REQ-031 Shared package: opcode constants (OP, OP_IMM, LUI), funct3 codes (ADD, SLL, SRL, AND), ALU_LAT.
REQ-032 One sub-module: regfile (32x32, two combinational read ports plus debug port, one write port, bypass, x0 rule).

Verification
REQ-033 addi x1,x0,5 (0x00500093) -> next cycle in_valid=1, a=0, b=5, funct3=000, r_i_s=1; after ALU result, dbg x1=5.
REQ-034 0x00500093 then add x2,x1,x1 (0x00108133) -> instr_ready low 2 cycles, then a=5, b=5 issued; x2=10.
REQ-035 x1=5, slli x3,x1,4 (0x00409193) -> b=4, funct3=001; x3=80.
REQ-036 addi x0,x0,7 (0x00700013) -> issued, b=7; dbg x0 reads 0 afterwards.
REQ-037 sub x4,x1,x2 (0x40208233) -> illegal=1 one cycle, in_valid=0, x4 unchanged, instr_ready stays 1.
REQ-038 addi x5,x0,9 (0x00900293) accepted, rst low next cycle -> in_valid=0, x5=0 after ALU latency, instr_ready=1 after release.
